// File: rtl/usb_rx_decoder_if.sv
// Line-side and bit-timer signals of the USB full-speed receive front end.
// The master drives the raw lines and shift_en; the slave (decoder) returns the decoded bit status.
interface usb_rx_decoder_if;
  logic d_plus;
  logic d_minus;
  logic shift_en;
  logic d_edge;
  logic d_orig;
  logic bit_stuff;
  logic eop;
  logic stuff_err;

  modport master (
    output d_plus, d_minus, shift_en,
    input  d_edge, d_orig, bit_stuff, eop, stuff_err
  );

  modport slave (
    input  d_plus, d_minus, shift_en,
    output d_edge, d_orig, bit_stuff, eop, stuff_err
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: line synchroniser, edge detect, NRZI decode, bit-stuff and SE0 detection.
// Optional macro USB_RX_STUFF_ERR_EN enables the stuff_err pulse on a missing stuff transition.
module usb_rx_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int STUFF_LEN   = 6
) (
  input  logic            clk,
  input  logic            rst,
  usb_rx_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] dp_sync;
  logic [SYNC_STAGES-1:0] dm_sync;
  logic                   dp_s;
  logic                   dm_s;
  logic                   dp_s_q;
  logic                   d_edge_q;

  logic                   prev_d,    prev_d_n;
  logic [CNT_W-1:0]       ones_cnt,  ones_cnt_n;
  logic                   d_orig_q,  d_orig_n;
  logic                   stuff_q,   stuff_n;
  logic                   eop_q,     eop_n;
  logic                   err_q,     err_n;
  logic                   se0;
  logic                   decoded;

  // Synchronisers reset to idle J (D+ high, D- low) so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync  <= '1;
      dm_sync  <= '0;
      dp_s_q   <= 1'b1;
      d_edge_q <= 1'b0;
    end else begin
      dp_sync  <= {dp_sync[SYNC_STAGES-2:0], bus.d_plus};
      dm_sync  <= {dm_sync[SYNC_STAGES-2:0], bus.d_minus};
      dp_s_q   <= dp_s;
      d_edge_q <= dp_s ^ dp_s_q;
    end
  end

  assign dp_s    = dp_sync[SYNC_STAGES-1];
  assign dm_s    = dm_sync[SYNC_STAGES-1];
  assign se0     = ~dp_s & ~dm_s;
  assign decoded = (dp_s == prev_d);

  always_comb begin
    prev_d_n   = prev_d;
    ones_cnt_n = ones_cnt;
    d_orig_n   = d_orig_q;
    stuff_n    = stuff_q;
    eop_n      = eop_q;
    err_n      = 1'b0;
    if (bus.shift_en) begin
      if (se0) begin
        // SE0 wins over a pending stuff bit; prev_d=1 makes the following J decode as a 1.
        eop_n      = 1'b1;
        d_orig_n   = 1'b0;
        ones_cnt_n = '0;
        stuff_n    = 1'b0;
        prev_d_n   = 1'b1;
      end else begin
        eop_n    = 1'b0;
        d_orig_n = decoded;
        prev_d_n = dp_s;
        if (ones_cnt == CNT_FULL) begin
          stuff_n    = 1'b0;
          ones_cnt_n = '0;
`ifdef USB_RX_STUFF_ERR_EN
          // A missing transition in the stuff slot is itself the first one of a new run.
          if (decoded) begin
            err_n      = 1'b1;
            ones_cnt_n = CNT_ONE;
          end
`endif
        end else if (decoded) begin
          ones_cnt_n = ones_cnt + CNT_ONE;
          stuff_n    = (ones_cnt + CNT_ONE == CNT_FULL);
        end else begin
          ones_cnt_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_d   <= 1'b1;
      ones_cnt <= '0;
      d_orig_q <= 1'b1;
      stuff_q  <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_d   <= prev_d_n;
      ones_cnt <= ones_cnt_n;
      d_orig_q <= d_orig_n;
      stuff_q  <= stuff_n;
      eop_q    <= eop_n;
      err_q    <= err_n;
    end
  end

  assign bus.d_edge    = d_edge_q;
  assign bus.d_orig    = d_orig_q;
  assign bus.bit_stuff = stuff_q;
  assign bus.eop       = eop_q;
  assign bus.stuff_err = err_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// Scoreboard bench for usb_rx_decoder: directed line vectors with hand-computed decode results.
// Expectations for the stuff-slot error follow USB_RX_STUFF_ERR_EN when it is defined.
module tb_usb_rx_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int STUFF_LEN   = 6;
`ifdef USB_RX_STUFF_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic d_orig;
    logic bit_stuff;
    logic eop;
    logic stuff_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   edge_q[$];

  usb_rx_decoder_if tif ();

  usb_rx_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .STUFF_LEN  (STUFF_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one line state, let it settle through the synchroniser, then issue a shift_en pulse.
  task automatic applyStimulus(input logic dp, input logic dm, input logic e_orig,
                               input logic e_stuff, input logic e_eop, input logic e_err);
    exp_t e;
    if (dp !== tif.d_plus) edge_q.push_back(cyc + SYNC_STAGES + 1);
    tif.d_plus  = dp;
    tif.d_minus = dm;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    e.d_orig    = e_orig;
    e.bit_stuff = e_stuff;
    e.eop       = e_eop;
    e.stuff_err = e_err;
    exp_q.push_back(e);
    tif.shift_en = 1'b1;
    @(posedge clk);
    #1;
    tif.shift_en = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput({tag, "_d_orig"},    32'(tif.d_orig),    32'd1);
    checkOutput({tag, "_eop"},       32'(tif.eop),       32'd0);
    checkOutput({tag, "_bit_stuff"}, 32'(tif.bit_stuff), 32'd0);
    checkOutput({tag, "_d_edge"},    32'(tif.d_edge),    32'd0);
    checkOutput({tag, "_stuff_err"}, 32'(tif.stuff_err), 32'd0);
  endtask

  // Sample monitor: compares after every edge on which shift_en was accepted.
  always begin
    @(posedge clk);
    if (tif.shift_en && !rst) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got a sample, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("d_orig",    32'(tif.d_orig),    32'(e.d_orig));
        checkOutput("bit_stuff", 32'(tif.bit_stuff), 32'(e.bit_stuff));
        checkOutput("eop",       32'(tif.eop),       32'(e.eop));
        checkOutput("stuff_err", 32'(tif.stuff_err), 32'(e.stuff_err));
      end
    end
  end

  // Edge monitor: every d_edge pulse must land on the cycle predicted from its pin change.
  always begin
    @(posedge clk);
    #1;
    if (!rst && tif.d_edge) begin
      if (edge_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL d_edge_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        checkOutput("d_edge_cycle", 32'(cyc), 32'(edge_q.pop_front()));
      end
    end
  end

  initial begin
    tif.d_plus   = 1'b1;
    tif.d_minus  = 1'b0;
    tif.shift_en = 1'b0;
    applyReset("reset");

    // NRZI: J,K,K,J from prev_d=1 decodes to 1,0,1,0
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Stuffing: six J ones, then the K stuff bit
    for (int i = 1; i <= STUFF_LEN; i++) applyStimulus(1, 0, 1, (i == STUFF_LEN), 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Six K ones, then a K in the stuff slot (no transition)
    for (int i = 1; i <= STUFF_LEN; i++) applyStimulus(0, 1, 1, (i == STUFF_LEN), 0, 0);
    applyStimulus(0, 1, 1, 0, 0, ERR_EN);
    @(posedge clk);
    #1;
    checkOutput("stuff_err_width", 32'(tif.stuff_err), 32'd0);
    // With the error path the run restarted at 1, so five more ones fill it
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 1, (i == 5) ? ERR_EN : 1'b0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // EOP: SE0 while bit_stuff is pending, SE0 again, then J
    for (int i = 1; i <= STUFF_LEN; i++) applyStimulus(1, 0, 1, (i == STUFF_LEN), 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);

    // Mid-packet reset with ones_cnt=4, then a full run is needed again
    for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    applyReset("mid_reset");
    for (int i = 1; i <= STUFF_LEN; i++) applyStimulus(1, 0, 1, (i == STUFF_LEN), 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("sb_leftover",   32'(exp_q.size()),  32'd0);
    checkOutput("edge_leftover", 32'(edge_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
